// File: rtl/pc_sequencer.sv
// Program-counter sequencer: architectural PC, next-PC select with misaligned-target
// trapping, and a circular return-address stack for predicted returns.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter int              RAS_DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            pc_reset_n,
  input  logic            pc_write,
  input  logic [2:0]      pc_source,
  input  logic [XLEN-1:0] jalr,
  input  logic [XLEN-1:0] branch,
  input  logic [XLEN-1:0] jal,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_4,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid,
  output logic            misalign_fault,
  output logic [XLEN-1:0] fault_addr
);

  localparam int           PW       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW:0]  CNT_FULL = (PW+1)'(RAS_DEPTH);

  logic [XLEN-1:0]                 pc_q;
  logic [RAS_DEPTH-1:0][XLEN-1:0]  ras_q;
  logic [PW-1:0]                   wr_ptr;
  logic [PW-1:0]                   top_ptr;
  logic [PW:0]                     cnt;
  logic                            fault_q;
  logic [XLEN-1:0]                 fault_addr_q;

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] trap_vec;
  logic [XLEN-1:0] next_pc;
  logic            misalign;
  logic            ras_en;

  assign pc_out         = pc_q;
  assign pc_4           = pc_q + XLEN'(4);
  assign top_ptr        = wr_ptr - PW'(1);
  assign ras_valid      = (cnt != '0);
  assign ras_top        = ras_valid ? ras_q[top_ptr] : '0;
  assign misalign_fault = fault_q;
  assign fault_addr     = fault_addr_q;
  assign trap_vec       = {mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    target   = pc_4;
    misalign = 1'b0;
    unique case (pc_source)
      3'b000: target = pc_4;
      3'b001: target = {jalr[XLEN-1:1], 1'b0};
      3'b010: target = branch;
      3'b011: target = jal;
      3'b100: target = trap_vec;
      3'b101: target = {mepc[XLEN-1:2], 2'b00};
      3'b110: target = ras_valid ? ras_top : pc_4;
      3'b111: target = pc_q;
      default: target = pc_4;
    endcase
    // only the relative/indirect jumps can produce a misaligned target
    if (pc_source inside {3'b001, 3'b010, 3'b011})
      misalign = |target[1:0];
    next_pc = misalign ? trap_vec : target;
    ras_en  = pc_write & ~misalign;
  end

  always_ff @(posedge clk or negedge pc_reset_n) begin
    if (!pc_reset_n) begin
      pc_q         <= RESET_VECTOR;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      fault_q <= pc_write & misalign;
      if (pc_write) begin
        pc_q <= next_pc;
        if (misalign) fault_addr_q <= target;
      end
    end
  end

  // Pointer wraps naturally (power-of-two depth), so a push when full overwrites the oldest.
  always_ff @(posedge clk or negedge pc_reset_n) begin
    if (!pc_reset_n) begin
      ras_q  <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (ras_en) begin
      if (ras_push && ras_pop && ras_valid) begin
        ras_q[top_ptr] <= pc_4;
      end else if (ras_push) begin
        ras_q[wr_ptr] <= pc_4;
        wr_ptr        <= wr_ptr + PW'(1);
        if (cnt != CNT_FULL) cnt <= cnt + (PW+1)'(1);
      end else if (ras_pop && ras_valid) begin
        wr_ptr <= top_ptr;
        cnt    <= cnt - (PW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed + randomized bench for pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RV    = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        pc_reset_n;
  logic        pc_write;
  logic [2:0]  pc_source;
  logic [31:0] jalr, branch, jal, mtvec, mepc;
  logic        ras_push, ras_pop;
  logic [31:0] pc_out, pc_4, ras_top, fault_addr;
  logic        ras_valid, misalign_fault;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_fault;
  logic [31:0] m_faddr;

  always #5 clk = ~clk;

  pc_sequencer #(.XLEN(32), .RAS_DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk(clk), .pc_reset_n(pc_reset_n), .pc_write(pc_write), .pc_source(pc_source),
    .jalr(jalr), .branch(branch), .jal(jal), .mtvec(mtvec), .mepc(mepc),
    .ras_push(ras_push), .ras_pop(ras_pop), .pc_out(pc_out), .pc_4(pc_4),
    .ras_top(ras_top), .ras_valid(ras_valid), .misalign_fault(misalign_fault),
    .fault_addr(fault_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_ras.delete(); m_fault = 1'b0; m_faddr = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":pc_out"},     pc_out, m_pc);
    chk({tag, ":pc_4"},       pc_4, m_pc + 32'd4);
    chk({tag, ":ras_valid"},  {31'b0, ras_valid}, {31'b0, m_ras.size() != 0});
    chk({tag, ":ras_top"},    ras_top, (m_ras.size() != 0) ? m_ras[$] : 32'h0);
    chk({tag, ":fault"},      {31'b0, misalign_fault}, {31'b0, m_fault});
    chk({tag, ":fault_addr"}, fault_addr, m_faddr);
  endtask

  // Model the edge from the specification's rules, then apply it and compare.
  task automatic step(input string tag, input logic [2:0] s, input logic pw,
                      input logic pu, input logic po);
    logic [31:0] p4, t;
    logic        mis;
    pc_source = s; pc_write = pw; ras_push = pu; ras_pop = po;
    p4 = m_pc + 32'd4;
    case (s)
      3'd0: t = p4;
      3'd1: t = jalr & ~32'd1;
      3'd2: t = branch;
      3'd3: t = jal;
      3'd4: t = mtvec & ~32'd3;
      3'd5: t = mepc & ~32'd3;
      3'd6: t = (m_ras.size() != 0) ? m_ras[$] : p4;
      default: t = m_pc;
    endcase
    mis = (s >= 3'd1 && s <= 3'd3) && (t % 4 != 0);
    @(posedge clk);
    if (pw) begin
      m_fault = mis;
      if (mis) begin
        m_pc = mtvec & ~32'd3;
        m_faddr = t;
      end else begin
        m_pc = t;
        if (pu && po && m_ras.size() != 0) m_ras[$] = p4;
        else if (pu) begin
          m_ras.push_back(p4);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (po && m_ras.size() != 0) void'(m_ras.pop_back());
      end
    end else m_fault = 1'b0;
    #1;
    check_all(tag);
  endtask

  function automatic logic [31:0] rnd_tgt();
    return ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'd3);
  endfunction

  initial begin
    pc_reset_n = 1'b0; pc_write = 1'b0; pc_source = 3'd0;
    jalr = '0; branch = '0; jal = '0; mtvec = '0; mepc = '0;
    ras_push = 1'b0; ras_pop = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    pc_reset_n = 1'b1;

    // sequential fetch then stall
    for (int i = 0; i < 3; i++) step("seq", 3'd0, 1'b1, 1'b0, 1'b0);
    chk("seq_end", pc_out, 32'h10C);
    for (int i = 0; i < 2; i++) step("stall", 3'd0, 1'b0, 1'b1, 1'b0);
    chk("stall_hold", pc_out, 32'h10C);

    // call / return
    jal = 32'h200; step("go200", 3'd3, 1'b1, 1'b0, 1'b0);
    jal = 32'h400; step("call", 3'd3, 1'b1, 1'b1, 1'b0);
    chk("call_top", ras_top, 32'h204);
    step("ret", 3'd6, 1'b1, 1'b0, 1'b1);
    chk("ret_pc", pc_out, 32'h204);

    // overflow: 5 pushes, 5 pops
    for (int i = 0; i < 5; i++) begin
      jal = 32'h1000 + 32'(i) * 32'h100;
      step("push5", 3'd3, 1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < 5; i++) step("pop5", 3'd6, 1'b1, 1'b0, 1'b1);
    chk("pop5_empty", {31'b0, ras_valid}, 32'h0);

    // misaligned branch traps and discards push
    branch = 32'h302; mtvec = 32'h1001;
    step("mis_br", 3'd2, 1'b1, 1'b1, 1'b0);
    chk("mis_pc", pc_out, 32'h1000);
    chk("mis_addr", fault_addr, 32'h302);
    step("mis_clr", 3'd0, 1'b0, 1'b0, 1'b0);

    jalr = 32'h501; step("jalr", 3'd1, 1'b1, 1'b0, 1'b0);
    chk("jalr_pc", pc_out, 32'h500);
    mepc = 32'h603; step("mret", 3'd5, 1'b1, 1'b0, 1'b0);
    chk("mret_pc", pc_out, 32'h600);
    jalr = 32'h702; step("jalr_mis", 3'd1, 1'b1, 1'b0, 1'b0);
    step("hold", 3'd7, 1'b1, 1'b0, 1'b0);

    // wrap
    jal = 32'hFFFF_FFFC; step("to_top", 3'd3, 1'b1, 1'b0, 1'b0);
    step("wrap", 3'd0, 1'b1, 1'b0, 1'b0);
    chk("wrap_pc", pc_out, 32'h0);

    // async reset with two entries and a pending fault pulse
    step("pre_rst_a", 3'd0, 1'b1, 1'b1, 1'b0);
    step("pre_rst_b", 3'd0, 1'b1, 1'b1, 1'b0);
    jal = 32'h801; step("pre_rst_f", 3'd3, 1'b1, 1'b0, 1'b0);
    #2 pc_reset_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clk);
    pc_reset_n = 1'b1;

    // randomized
    for (int i = 0; i < 400; i++) begin
      jalr = rnd_tgt(); branch = rnd_tgt(); jal = rnd_tgt();
      mtvec = $urandom; mepc = $urandom;
      step("rand", 3'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0),
           1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the multicycle RISC-V core, the next generation of the PC select/register logic. Holds the architectural PC, selects the next PC from sequential, jump, branch, trap and trap-return targets, and adds a return-address stack (RAS) for predicted returns. It also detects misaligned control-transfer targets and redirects them to the trap vector. It sits between the control FSM (source select, write enable, RAS push/pop) and the instruction-memory address port.

## Interface
- XLEN, 32, PC and target width
- RAS_DEPTH, 4, RAS entries (power of two, 2..16)
- RESET_VECTOR, 32'h0000_0000, PC value after reset
- clk  in  1  clock, rising edge
- pc_reset_n  in  1  asynchronous, active-low reset
- pc_write  in  1  PC/RAS update enable; 0 = stall, all state holds
- pc_source  in  3  next-PC select
- jalr, branch, jal, mtvec, mepc  in  XLEN  candidate targets
- ras_push  in  1  push return address (call)
- ras_pop  in  1  pop RAS (return)
- pc_out  out  XLEN  current PC (registered)
- pc_4  out  XLEN  pc_out + 4 (combinational)
- ras_top  out  XLEN  top RAS entry (combinational; 0 when empty)
- ras_valid  out  1  RAS non-empty
- misalign_fault  out  1  one-cycle pulse: last redirect was misaligned
- fault_addr  out  XLEN  offending target, held until next fault

## Operation
- pc_source: 000 pc_4; 001 {jalr[XLEN-1:1],0}; 010 branch; 011 jal; 100 {mtvec[XLEN-1:2],00}; 101 {mepc[XLEN-1:2],00}; 110 ras_top if ras_valid, else pc_4; 111 hold (pc_out).
- Misalignment check applies to 001, 010, 011 only: selected target bits [1:0] != 0 → PC loads {mtvec[XLEN-1:2],00}, fault_addr loads the target, misalign_fault set for one cycle.
- RAS: circular buffer, write pointer + count (0..RAS_DEPTH).
  - Push stores pc_4 at top; count increments, saturates at RAS_DEPTH; when full the oldest entry is overwritten.
  - Pop removes top; count decrements; pop when empty is a no-op.
  - Push and pop together: top entry replaced by pc_4, count unchanged (if empty: behaves as push).
  - Push/pop take effect only when pc_write=1 and no misalignment fault that cycle.
- Arithmetic modulo 2^XLEN: pc_4 of all-ones-minus-3 wraps to 0.
- Source 110 with RAS empty is not a fault; falls back to pc_4, RAS unchanged unless ras_pop (no-op) / ras_push.

## Timing
- Reset (pc_reset_n low, asynchronous): pc_out = RESET_VECTOR, RAS count 0, all entries 0, misalign_fault 0, fault_addr 0; hence pc_4 = RESET_VECTOR+4, ras_top 0, ras_valid 0. Reset release takes effect on the next rising edge; first update at the first edge with pc_write=1.
- pc_out, RAS state, fault_addr update on rising clk when pc_write=1; one-cycle latency from inputs to pc_out.
- misalign_fault is registered: high exactly the cycle after the faulting edge; cleared at the next edge regardless of pc_write.
- pc_4, ras_top, ras_valid are combinational from registered state; ras_top reflects a push/pop in the cycle after the edge.
- pc_write=0: all inputs ignored (except reset); misalign_fault still clears.
- Reset asserted mid-operation clears the RAS and any pending fault pulse immediately.

## Test plan
- Reset with RESET_VECTOR=32'h0000_0100, then 3 cycles source 000, pc_write=1 → pc_out 0x100, 0x104, 0x108, 0x10C; pc_write=0 for 2 cycles → pc_out holds 0x10C.
- At pc_out 0x200 source 011 jal=0x400 with ras_push → pc_out 0x400, ras_top 0x204, ras_valid 1; then source 110 with ras_pop → pc_out 0x204, ras_valid 0.
- RAS_DEPTH=4: push 5 times (return addrs A1..A5) then pop 5 times using source 110 → targets A5, A4, A3, A2, then pc_4 fallback (RAS empty), ras_valid 0 after 4th pop.
- Source 010 branch=0x302, mtvec=0x1001 → pc_out 0x1000, misalign_fault high one cycle, fault_addr 0x302; a ras_push in the same cycle is discarded.
- Source 001 jalr=0x501 → pc_out 0x500, no fault; source 101 mepc=0x603 → pc_out 0x600, no fault.
- pc_out 0xFFFF_FFFC, source 000 → pc_out 0x0000_0000; assert pc_reset_n low mid-cycle with 2 RAS entries → pc_out RESET_VECTOR and ras_valid 0 before next edge.
